// File: rtl/pill_fill_pkg.sv
// Shared encodings and BCD helpers for the pill-bottling controller.
// Optional pause feature is enabled in the top by defining PILL_CTRL_PAUSE_EN.
package pill_fill_pkg;

   typedef enum logic [2:0] {
      ST_SETTING   = 3'd0,
      ST_RUNNING   = 3'd1,
      ST_SWITCHING = 3'd2,
      ST_DONE      = 3'd3,
      ST_ERROR     = 3'd4,
      ST_FATAL     = 3'd5,
      ST_PAUSED    = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_HOPPER   = 2'd1,
      ERR_CONVEYOR = 2'd2
   } err_e;

   typedef enum logic [1:0] {
      BEEP_OFF    = 2'd0,
      BEEP_STEADY = 2'd1,
      BEEP_2HZ    = 2'd2,
      BEEP_4HZ    = 2'd3
   } beep_e;

   function automatic logic [3:0] dig_inc_f(input logic [3:0] d);
      return (d >= 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

   // Ripple-carry BCD increment over up to four digits; callers truncate to their width.
   function automatic logic [15:0] bcd_inc_f(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            r[4*i +: 4] = dig_inc_f(v[4*i +: 4]);
            c = (v[4*i +: 4] >= 4'd9);
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction

   function automatic logic [1:0] beep_f(input state_e s);
      case (s)
         ST_DONE:  return BEEP_STEADY;
         ST_ERROR: return BEEP_2HZ;
         ST_FATAL: return BEEP_4HZ;
         default:  return BEEP_OFF;
      endcase
   endfunction

endpackage

// File: rtl/pill_fill_ctrl_bcd_counter.sv
// Multi-digit BCD counter with synchronous clear (dominant) and increment.
module bcd_counter
   import pill_fill_pkg::*;
#(
   parameter int DIGITS = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clr_i,
   input  logic                  inc_i,
   output logic [4*DIGITS-1:0]   count_o
);

   logic [4*DIGITS-1:0] count_q, count_d;

   // Next count: clear beats increment.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = {(4*DIGITS){1'b0}};
      end else if (inc_i) begin
         count_d = (4*DIGITS)'(bcd_inc_f(16'(count_q)));
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= {(4*DIGITS){1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/pill_fill_ctrl.sv
// Pill-bottling controller: target entry, pill/bottle counting, changeover and fault sequencing.
// Define PILL_CTRL_PAUSE_EN to add the btn_pause input and the PAUSED state.
module pill_fill_ctrl
   import pill_fill_pkg::*;
#(
   parameter int PILL_DIGITS   = 3,
   parameter int BOTTLE_DIGITS = 2,
   parameter int SWITCH_TICKS  = 2,
   parameter int HOPPER_TICKS  = 5
) (
   input  logic                                         clk_1khz,
   input  logic                                         switch_clr,
   input  logic                                         tick_1s,
   input  logic                                         btn_pos,
   input  logic                                         btn_inc,
   input  logic                                         btn_start,
   input  logic                                         btn_ack,
   input  logic                                         emergency_stop,
   input  logic                                         hopper_pulse,
   input  logic                                         conveyor_ok,
`ifdef PILL_CTRL_PAUSE_EN
   input  logic                                         btn_pause,
`endif
   output logic [2:0]                                   state_o,
   output logic [$clog2(PILL_DIGITS+BOTTLE_DIGITS)-1:0] cursor_o,
   output logic [4*PILL_DIGITS-1:0]                     target_pills_o,
   output logic [4*BOTTLE_DIGITS-1:0]                   target_bottles_o,
   output logic [4*PILL_DIGITS-1:0]                     now_pills_o,
   output logic [4*BOTTLE_DIGITS-1:0]                   now_bottles_o,
   output logic [1:0]                                   err_code_o,
   output logic [1:0]                                   beep_mode_o
);

   localparam int ND = PILL_DIGITS + BOTTLE_DIGITS;
   localparam int CW = $clog2(ND);
   localparam int PW = 4 * PILL_DIGITS;
   localparam int BW = 4 * BOTTLE_DIGITS;
   localparam int HW = $clog2(HOPPER_TICKS + 1);
   localparam int SW = $clog2(SWITCH_TICKS + 1);

   state_e          state_q, state_d;
   err_e            err_q, err_d;
   logic [CW-1:0]   cursor_q, cursor_d, cursor_nxt_s;
   logic [PW-1:0]   tgt_p_q, tgt_p_d, tgt_p_inc_s, now_p_s, p_next_s;
   logic [BW-1:0]   tgt_b_q, tgt_b_d, tgt_b_inc_s, now_b_s, b_next_s;
   logic [HW-1:0]   hop_tmr_q, hop_tmr_d;
   logic [SW-1:0]   sw_tmr_q, sw_tmr_d;
   logic            hop_q;
   logic            pill_edge_s, count_s;
   logic            p_clr_s, p_inc_s, b_clr_s, b_inc_s;
`ifdef PILL_CTRL_PAUSE_EN
   state_e          saved_q, saved_d;
`endif

   assign pill_edge_s  = hopper_pulse & ~hop_q;
   assign p_next_s     = PW'(bcd_inc_f(16'(now_p_s)));
   assign b_next_s     = BW'(bcd_inc_f(16'(now_b_s)));
   assign cursor_nxt_s = (cursor_q == CW'(ND - 1)) ? {CW{1'b0}} : cursor_q + CW'(1);

   for (genvar i = 0; i < PILL_DIGITS; i++) begin : g_pill_dig
      assign tgt_p_inc_s[4*i +: 4] = (btn_inc && cursor_q == CW'(i)) ?
                                     dig_inc_f(tgt_p_q[4*i +: 4]) : tgt_p_q[4*i +: 4];
   end
   for (genvar i = 0; i < BOTTLE_DIGITS; i++) begin : g_btl_dig
      assign tgt_b_inc_s[4*i +: 4] = (btn_inc && cursor_q == CW'(PILL_DIGITS + i)) ?
                                     dig_inc_f(tgt_b_q[4*i +: 4]) : tgt_b_q[4*i +: 4];
   end

   // Next-state and datapath control; emergency stop overrides everything.
   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      cursor_d  = cursor_q;
      tgt_p_d   = tgt_p_q;
      tgt_b_d   = tgt_b_q;
      hop_tmr_d = hop_tmr_q;
      sw_tmr_d  = sw_tmr_q;
      p_clr_s   = 1'b0;
      p_inc_s   = 1'b0;
      b_clr_s   = 1'b0;
      b_inc_s   = 1'b0;
      count_s   = 1'b0;
`ifdef PILL_CTRL_PAUSE_EN
      saved_d   = saved_q;
`endif
      if (emergency_stop) begin
         state_d = ST_FATAL;
      end else begin
         case (state_q)
            ST_SETTING: begin
               tgt_p_d  = tgt_p_inc_s;
               tgt_b_d  = tgt_b_inc_s;
               cursor_d = btn_pos ? cursor_nxt_s : cursor_q;
               if (btn_start && tgt_p_q != {PW{1'b0}} && tgt_b_q != {BW{1'b0}}) begin
                  state_d   = ST_RUNNING;
                  p_clr_s   = 1'b1;
                  b_clr_s   = 1'b1;
                  hop_tmr_d = HW'(HOPPER_TICKS);
               end else begin
                  state_d = ST_SETTING;
               end
            end
            ST_RUNNING: begin
`ifdef PILL_CTRL_PAUSE_EN
               if (btn_pause) begin
                  state_d = ST_PAUSED;
                  saved_d = ST_RUNNING;
               end else
`endif
               if (pill_edge_s) begin
                  count_s = 1'b1;
               end else if (tick_1s) begin
                  if (hop_tmr_q <= HW'(1)) begin
                     hop_tmr_d = {HW{1'b0}};
                     state_d   = ST_ERROR;
                     err_d     = ERR_HOPPER;
                  end else begin
                     hop_tmr_d = hop_tmr_q - HW'(1);
                  end
               end else begin
                  hop_tmr_d = hop_tmr_q;
               end
            end
            ST_SWITCHING: begin
`ifdef PILL_CTRL_PAUSE_EN
               if (btn_pause) begin
                  state_d = ST_PAUSED;
                  saved_d = ST_SWITCHING;
               end else
`endif
               if (tick_1s) begin
                  if (sw_tmr_q <= SW'(1)) begin
                     sw_tmr_d = {SW{1'b0}};
                     if (conveyor_ok) begin
                        state_d   = ST_RUNNING;
                        hop_tmr_d = HW'(HOPPER_TICKS);
                     end else begin
                        state_d = ST_ERROR;
                        err_d   = ERR_CONVEYOR;
                     end
                  end else begin
                     sw_tmr_d = sw_tmr_q - SW'(1);
                  end
               end else begin
                  sw_tmr_d = sw_tmr_q;
               end
            end
            ST_DONE: begin
               state_d = btn_ack ? ST_SETTING : ST_DONE;
            end
            ST_ERROR: begin
               if (btn_ack) begin
                  state_d = ST_SETTING;
                  err_d   = ERR_NONE;
               end else if (err_q == ERR_HOPPER && pill_edge_s) begin
                  count_s = 1'b1;
               end else if (err_q == ERR_CONVEYOR && conveyor_ok) begin
                  state_d   = ST_RUNNING;
                  err_d     = ERR_NONE;
                  hop_tmr_d = HW'(HOPPER_TICKS);
               end else begin
                  state_d = ST_ERROR;
               end
            end
            ST_FATAL: begin
               if (btn_ack) begin
                  state_d = ST_SETTING;
                  err_d   = ERR_NONE;
               end else begin
                  state_d = ST_FATAL;
               end
            end
`ifdef PILL_CTRL_PAUSE_EN
            ST_PAUSED: begin
               state_d = btn_pause ? saved_q : ST_PAUSED;
            end
`endif
            default: begin
               state_d = ST_SETTING;
               err_d   = ERR_NONE;
            end
         endcase
         // A counted pill may complete a bottle, and that bottle may complete the batch.
         if (count_s) begin
            p_inc_s   = 1'b1;
            hop_tmr_d = HW'(HOPPER_TICKS);
            state_d   = ST_RUNNING;
            err_d     = ERR_NONE;
            if (p_next_s == tgt_p_q) begin
               b_inc_s = 1'b1;
               if (b_next_s == tgt_b_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d  = ST_SWITCHING;
                  p_clr_s  = 1'b1;
                  sw_tmr_d = SW'(SWITCH_TICKS);
               end
            end else begin
               b_inc_s = 1'b0;
            end
         end else begin
            p_inc_s = 1'b0;
         end
      end
   end

   // Control and target registers.
   always_ff @(posedge clk_1khz or negedge switch_clr) begin
      if (!switch_clr) begin
         state_q   <= ST_SETTING;
         err_q     <= ERR_NONE;
         cursor_q  <= {CW{1'b0}};
         tgt_p_q   <= {PW{1'b0}};
         tgt_b_q   <= {BW{1'b0}};
         hop_tmr_q <= {HW{1'b0}};
         sw_tmr_q  <= {SW{1'b0}};
         hop_q     <= 1'b0;
`ifdef PILL_CTRL_PAUSE_EN
         saved_q   <= ST_SETTING;
`endif
      end else begin
         state_q   <= state_d;
         err_q     <= err_d;
         cursor_q  <= cursor_d;
         tgt_p_q   <= tgt_p_d;
         tgt_b_q   <= tgt_b_d;
         hop_tmr_q <= hop_tmr_d;
         sw_tmr_q  <= sw_tmr_d;
         hop_q     <= hopper_pulse;
`ifdef PILL_CTRL_PAUSE_EN
         saved_q   <= saved_d;
`endif
      end
   end

   bcd_counter #(.DIGITS(PILL_DIGITS)) u_pills (
      .clk_i   (clk_1khz),
      .rst_ni  (switch_clr),
      .clr_i   (p_clr_s),
      .inc_i   (p_inc_s),
      .count_o (now_p_s)
   );

   bcd_counter #(.DIGITS(BOTTLE_DIGITS)) u_bottles (
      .clk_i   (clk_1khz),
      .rst_ni  (switch_clr),
      .clr_i   (b_clr_s),
      .inc_i   (b_inc_s),
      .count_o (now_b_s)
   );

   assign state_o          = state_q;
   assign err_code_o       = err_q;
   assign cursor_o         = cursor_q;
   assign target_pills_o   = tgt_p_q;
   assign target_bottles_o = tgt_b_q;
   assign now_pills_o      = now_p_s;
   assign now_bottles_o    = now_b_s;
   assign beep_mode_o      = beep_f(state_q);

endmodule

// File: tb/tb_pill_fill_ctrl.sv
// Directed self-checking bench for pill_fill_ctrl with default parameters.
module tb_pill_fill_ctrl;

   localparam int B_POS   = 0;
   localparam int B_INC   = 1;
   localparam int B_START = 2;
   localparam int B_ACK   = 3;
   localparam int B_TICK  = 4;
   localparam int B_PAUSE = 5;

   logic        clk_1khz;
   logic        switch_clr;
   logic        tick_1s;
   logic        btn_pos;
   logic        btn_inc;
   logic        btn_start;
   logic        btn_ack;
   logic        emergency_stop;
   logic        hopper_pulse;
   logic        conveyor_ok;
   logic        btn_pause;
   logic [2:0]  state_o;
   logic [2:0]  cursor_o;
   logic [11:0] target_pills_o;
   logic [7:0]  target_bottles_o;
   logic [11:0] now_pills_o;
   logic [7:0]  now_bottles_o;
   logic [1:0]  err_code_o;
   logic [1:0]  beep_mode_o;

   int n_cmp = 0;
   int n_bad = 0;

   pill_fill_ctrl dut (
      .clk_1khz         (clk_1khz),
      .switch_clr       (switch_clr),
      .tick_1s          (tick_1s),
      .btn_pos          (btn_pos),
      .btn_inc          (btn_inc),
      .btn_start        (btn_start),
      .btn_ack          (btn_ack),
      .emergency_stop   (emergency_stop),
      .hopper_pulse     (hopper_pulse),
      .conveyor_ok      (conveyor_ok),
`ifdef PILL_CTRL_PAUSE_EN
      .btn_pause        (btn_pause),
`endif
      .state_o          (state_o),
      .cursor_o         (cursor_o),
      .target_pills_o   (target_pills_o),
      .target_bottles_o (target_bottles_o),
      .now_pills_o      (now_pills_o),
      .now_bottles_o    (now_bottles_o),
      .err_code_o       (err_code_o),
      .beep_mode_o      (beep_mode_o)
   );

   initial clk_1khz = 1'b0;
   always #5 clk_1khz = ~clk_1khz;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic press(input int b, input int n);
      repeat (n) begin
         case (b)
            B_POS:   btn_pos   = 1'b1;
            B_INC:   btn_inc   = 1'b1;
            B_START: btn_start = 1'b1;
            B_ACK:   btn_ack   = 1'b1;
            B_TICK:  tick_1s   = 1'b1;
            B_PAUSE: btn_pause = 1'b1;
            default: ;
         endcase
         @(negedge clk_1khz);
         btn_pos   = 1'b0;
         btn_inc   = 1'b0;
         btn_start = 1'b0;
         btn_ack   = 1'b0;
         tick_1s   = 1'b0;
         btn_pause = 1'b0;
      end
   endtask

   task automatic pill(input int n);
      repeat (n) begin
         hopper_pulse = 1'b1;
         @(negedge clk_1khz);
         hopper_pulse = 1'b0;
         @(negedge clk_1khz);
      end
   endtask

   initial begin
      switch_clr = 1'b0; tick_1s = 1'b0; btn_pos = 1'b0; btn_inc = 1'b0;
      btn_start = 1'b0; btn_ack = 1'b0; emergency_stop = 1'b0;
      hopper_pulse = 1'b0; conveyor_ok = 1'b1; btn_pause = 1'b0;
      repeat (3) @(negedge clk_1khz);
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_cursor", 32'(cursor_o), 32'd0);
      check("rst_tgt_p", 32'(target_pills_o), 32'h000);
      check("rst_err", 32'(err_code_o), 32'd0);
      check("rst_beep", 32'(beep_mode_o), 32'd0);
      switch_clr = 1'b1;
      @(negedge clk_1khz);

      // Cursor wrap and digit increment
      press(B_POS, 7);
      check("cursor_7pos", 32'(cursor_o), 32'd2);
      press(B_INC, 11);
      check("tgt_p_11inc", 32'(target_pills_o), 32'h100);
      check("tgt_b_11inc", 32'(target_bottles_o), 32'h00);
      press(B_START, 1);
      check("start_b0_ignored", 32'(state_o), 32'd0);

      // Targets pills=003 bottles=02; simultaneous inc+pos at the end
      press(B_INC, 9);
      press(B_POS, 1);
      press(B_INC, 2);
      press(B_POS, 2);
      press(B_INC, 2);
      btn_inc = 1'b1; btn_pos = 1'b1;
      @(negedge clk_1khz);
      btn_inc = 1'b0; btn_pos = 1'b0;
      check("tgt_p_set", 32'(target_pills_o), 32'h003);
      check("tgt_b_set", 32'(target_bottles_o), 32'h02);
      check("inc_pos_cursor", 32'(cursor_o), 32'd1);

      // Full batch
      press(B_START, 1);
      check("run_state", 32'(state_o), 32'd1);
      check("run_now_p0", 32'(now_pills_o), 32'h000);
      pill(2);
      check("run_now_p2", 32'(now_pills_o), 32'h002);
      pill(1);
      check("sw_state", 32'(state_o), 32'd2);
      check("sw_now_b", 32'(now_bottles_o), 32'h01);
      check("sw_now_p", 32'(now_pills_o), 32'h000);
      pill(1);
      check("sw_edge_ignored", 32'(now_pills_o), 32'h000);
      press(B_TICK, 1);
      check("sw_after_1tick", 32'(state_o), 32'd2);
      press(B_TICK, 1);
      check("sw_to_run", 32'(state_o), 32'd1);
      pill(3);
      check("done_state", 32'(state_o), 32'd3);
      check("done_now_b", 32'(now_bottles_o), 32'h02);
      check("done_now_p", 32'(now_pills_o), 32'h003);
      check("done_beep", 32'(beep_mode_o), 32'd1);
      press(B_ACK, 1);
      check("done_ack", 32'(state_o), 32'd0);
      check("done_ack_tgt", 32'(target_pills_o), 32'h003);

      // Hopper starvation
      press(B_START, 1);
      check("restart_now_b", 32'(now_bottles_o), 32'h00);
      press(B_TICK, 4);
      check("hop_4ticks", 32'(state_o), 32'd1);
      press(B_TICK, 1);
      check("hop_err_state", 32'(state_o), 32'd4);
      check("hop_err_code", 32'(err_code_o), 32'd1);
      check("hop_err_beep", 32'(beep_mode_o), 32'd2);
      pill(1);
      check("hop_recover", 32'(state_o), 32'd1);
      check("hop_recover_p", 32'(now_pills_o), 32'h001);
      check("hop_recover_err", 32'(err_code_o), 32'd0);

      // Conveyor fault at end of changeover
      pill(2);
      check("sw2_state", 32'(state_o), 32'd2);
      conveyor_ok = 1'b0;
      press(B_TICK, 2);
      check("conv_err_state", 32'(state_o), 32'd4);
      check("conv_err_code", 32'(err_code_o), 32'd2);
      conveyor_ok = 1'b1;
      @(negedge clk_1khz);
      check("conv_recover", 32'(state_o), 32'd1);
      check("conv_recover_p", 32'(now_pills_o), 32'h000);

      // Emergency stop
      emergency_stop = 1'b1;
      @(negedge clk_1khz);
      check("fatal_state", 32'(state_o), 32'd5);
      check("fatal_beep", 32'(beep_mode_o), 32'd3);
      press(B_ACK, 1);
      check("fatal_ack_held", 32'(state_o), 32'd5);
      emergency_stop = 1'b0;
      @(negedge clk_1khz);
      check("fatal_released", 32'(state_o), 32'd5);
      press(B_ACK, 1);
      check("fatal_ack", 32'(state_o), 32'd0);
      check("fatal_tgt_p", 32'(target_pills_o), 32'h003);
      check("fatal_tgt_b", 32'(target_bottles_o), 32'h02);

`ifdef PILL_CTRL_PAUSE_EN
      press(B_START, 1);
      press(B_TICK, 2);
      press(B_PAUSE, 1);
      check("pause_state", 32'(state_o), 32'd6);
      check("pause_beep", 32'(beep_mode_o), 32'd0);
      press(B_TICK, 10);
      pill(1);
      check("pause_no_count", 32'(now_pills_o), 32'h000);
      press(B_PAUSE, 1);
      check("resume_state", 32'(state_o), 32'd1);
      press(B_TICK, 2);
      check("resume_2ticks", 32'(state_o), 32'd1);
      press(B_TICK, 1);
      check("resume_timeout", 32'(state_o), 32'd4);
      press(B_ACK, 1);
`endif

      // Reset mid-fill
      press(B_START, 1);
      pill(1);
      check("pre_rst_p", 32'(now_pills_o), 32'h001);
      switch_clr = 1'b0;
      #1;
      check("midrst_p", 32'(now_pills_o), 32'h000);
      check("midrst_state", 32'(state_o), 32'd0);
      check("midrst_tgt_p", 32'(target_pills_o), 32'h000);
      @(negedge clk_1khz);
      switch_clr = 1'b1;
      @(negedge clk_1khz);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
